// File: rtl/decoder_3x8_stream.sv
// -----------------------------------------------------------------------------
// decoder_3x8_stream
//
// Registered binary-to-one-hot decoder with valid/ready handshakes on both
// sides. A small FIFO (1 or 2 entries) sits between the producer and the
// consumer so that a downstream stall never drops a code.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   producer offers a code
//   in_ready   block can accept a code (depends on registered count only)
//   in_code    binary index to decode
//   in_en      decoder enable, sampled with in_code; 0 stores an all-zero word
//   out_valid  out_onehot holds a valid word
//   out_ready  consumer takes the word this cycle
//   out_onehot decoded word, zero whenever the buffer is empty
//   count      current buffer occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module decoder_3x8_stream #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(2**CODE_W)-1:0] out_onehot,
    output logic [1:0]             count
);

    localparam int         OUT_W    = 2**CODE_W;
    localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
    localparam logic       LAST_PTR = 1'(DEPTH - 1);

    // Decode one code into its select word; disabled codes give all zeros,
    // so a stored word is always one-hot or zero, never multi-hot.
    function automatic logic [OUT_W-1:0] decode_word(
        input logic [CODE_W-1:0] code,
        input logic              en
    );
        logic [OUT_W-1:0] word;
        word = {OUT_W{1'b0}};
        if (en) begin
            word[code] = 1'b1;
        end else begin
            word = {OUT_W{1'b0}};
        end
        return word;
    endfunction

    // Pointer increment wrapping modulo DEPTH (a DEPTH of 1 pins it at 0).
    function automatic logic ptr_inc(input logic p);
        return (p == LAST_PTR) ? 1'b0 : (p + 1'b1);
    endfunction

    logic [OUT_W-1:0] mem_r [2];
    logic [OUT_W-1:0] mem_nxt_s [2];
    logic             wr_ptr_r, wr_ptr_nxt_s;
    logic             rd_ptr_r, rd_ptr_nxt_s;
    logic [1:0]       count_r, count_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic [OUT_W-1:0] out_onehot_r, out_onehot_nxt_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;

    // in_ready looks only at the registered count: no pass-through when full.
    assign in_ready_s = (count_r < DEPTH_C);
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = out_valid_r && out_ready;

    // Next-state computation for storage, pointers, occupancy and the
    // registered output word (the head entry after this edge's push/pop).
    always_comb begin
        mem_nxt_s[0] = mem_r[0];
        mem_nxt_s[1] = mem_r[1];
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;

        if (push_s) begin
            mem_nxt_s[wr_ptr_r] = decode_word(in_code, in_en);
            wr_ptr_nxt_s        = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase

        // The head may be the entry written this same edge (push+pop at count 1).
        out_valid_nxt_s = (count_nxt_s != 2'd0);
        if (out_valid_nxt_s) begin
            out_onehot_nxt_s = mem_nxt_s[rd_ptr_nxt_s];
        end else begin
            out_onehot_nxt_s = {OUT_W{1'b0}};
        end
    end

    // State registers; synchronous reset discards every buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0]     <= {OUT_W{1'b0}};
            mem_r[1]     <= {OUT_W{1'b0}};
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            out_valid_r  <= 1'b0;
            out_onehot_r <= {OUT_W{1'b0}};
        end else begin
            mem_r[0]     <= mem_nxt_s[0];
            mem_r[1]     <= mem_nxt_s[1];
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_onehot_r <= out_onehot_nxt_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_onehot = out_onehot_r;
    assign count      = count_r;

endmodule
